frac_search_grid: RTL and testbench



---
 rtl/frac_search_pkg.sv | 38 +++
 rtl/frac_search_grid_if.sv | 32 +++
 rtl/frac_search_grid_row_sad.sv | 34 +++
 rtl/frac_search_grid.sv | 153 +++++++++++++++
 tb/tb_frac_search_grid.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/frac_search_pkg.sv
// Shared types and width helpers for the fractional-MV SAD search.
// Optional feature macro: FRAC_SEARCH_CENTER_BIAS_EN (see frac_search_grid.sv).
package frac_search_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((64'(1) << r) < 64'(v)) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

  // Counter/index width, never below one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  function automatic int sad_w(input int pix_w, input int row_pix, input int rows);
    return pix_w + clog2(row_pix * rows);
  endfunction

  function automatic int mv_w(input int grid);
    return cnt_w(grid);
  endfunction

  function automatic int center_idx(input int grid);
    return (grid * grid - 1) / 2;
  endfunction

endpackage

// File: rtl/frac_search_grid_if.sv
// Row-beat stream in, winning fractional MV out; master drives beats, slave is the searcher.
interface frac_search_grid_if
  import frac_search_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 8,
  parameter int ROWS    = 8,
  parameter int GRID    = 3
);
  localparam int SAD_W = sad_w(PIX_W, ROW_PIX, ROWS);
  localparam int MV_W  = mv_w(GRID);

  logic [ROW_PIX*PIX_W-1:0] filter_pix;
  logic [ROW_PIX*PIX_W-1:0] ref_pix;
  logic                     input_ready;
  logic                     in_ready;
  logic [MV_W-1:0]          mvx;
  logic [MV_W-1:0]          mvy;
  logic [SAD_W-1:0]         best_sad;
  logic                     mv_valid;

  modport master (
    output filter_pix, ref_pix, input_ready,
    input  in_ready, mvx, mvy, best_sad, mv_valid
  );

  modport slave (
    input  filter_pix, ref_pix, input_ready,
    output in_ready, mvx, mvy, best_sad, mv_valid
  );

endinterface

// File: rtl/frac_search_grid_row_sad.sv
// Combinational sum of absolute pixel differences across one row beat.
module row_sad
  import frac_search_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 8,
  localparam int OUT_W  = PIX_W + clog2(ROW_PIX)
) (
  input  logic [ROW_PIX*PIX_W-1:0] a,
  input  logic [ROW_PIX*PIX_W-1:0] b,
  output logic [OUT_W-1:0]         sad
);

  logic [PIX_W-1:0] pa;
  logic [PIX_W-1:0] pb;
  logic [PIX_W-1:0] diff;
  logic [OUT_W-1:0] sum;

  always_comb begin
    pa   = '0;
    pb   = '0;
    diff = '0;
    sum  = '0;
    for (int i = 0; i < ROW_PIX; i++) begin
      pa   = a[i*PIX_W +: PIX_W];
      pb   = b[i*PIX_W +: PIX_W];
      diff = (pa > pb) ? (pa - pb) : (pb - pa);
      sum  = sum + OUT_W'(diff);
    end
  end

  assign sad = sum;

endmodule

// File: rtl/frac_search_grid.sv
// Per-candidate SAD accumulation over a GRID x GRID fractional grid with min tracking.
// Define FRAC_SEARCH_CENTER_BIAS_EN to let the centre candidate win ties against the current best.
module frac_search_grid
  import frac_search_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 8,
  parameter int ROWS    = 8,
  parameter int GRID    = 3
) (
  input  logic               clk,
  input  logic               reset,
  frac_search_grid_if.slave  bus
);

  localparam int NUM_CAND = GRID * GRID;
  localparam int SAD_W    = sad_w(PIX_W, ROW_PIX, ROWS);
  localparam int RS_W     = PIX_W + clog2(ROW_PIX);
  localparam int MV_W     = mv_w(GRID);
  localparam int ROW_W    = cnt_w(ROWS);
  localparam int CAND_W   = cnt_w(NUM_CAND);
  localparam int CENTER   = center_idx(GRID);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CAND_W-1:0] cand_q, cand_d;
  logic [SAD_W-1:0]  acc_q, acc_d;
  logic [SAD_W-1:0]  best_q, best_d;
  logic [CAND_W-1:0] best_idx_q, best_idx_d;
  logic [MV_W-1:0]   mvx_q, mvx_d;
  logic [MV_W-1:0]   mvy_q, mvy_d;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;
  logic              mv_valid_q, mv_valid_d;
  logic              in_ready_q, in_ready_d;

  logic [RS_W-1:0]   row_sad_s;
  logic [SAD_W-1:0]  total_s;
  logic              accept_s;
  logic              last_row_s;
  logic              last_cand_s;
  logic              take_s;
  logic [CAND_W-1:0] win_idx_s;
  logic [SAD_W-1:0]  win_sad_s;

  row_sad #(
    .PIX_W   (PIX_W),
    .ROW_PIX (ROW_PIX)
  ) u_row_sad (
    .a   (bus.filter_pix),
    .b   (bus.ref_pix),
    .sad (row_sad_s)
  );

  assign accept_s    = bus.input_ready && (state_q == ACCUM);
  assign total_s     = acc_q + SAD_W'(row_sad_s);
  assign last_row_s  = (row_q == ROW_W'(ROWS - 1));
  assign last_cand_s = (cand_q == CAND_W'(NUM_CAND - 1));

  // Candidate 0 seeds the best; later ones must be strictly better (or the centre on a tie).
`ifdef FRAC_SEARCH_CENTER_BIAS_EN
  assign take_s = (cand_q == '0) || (total_s < best_q) ||
                  ((cand_q == CAND_W'(CENTER)) && (total_s == best_q));
`else
  assign take_s = (cand_q == '0) || (total_s < best_q);
`endif

  assign win_idx_s = take_s ? cand_q : best_idx_q;
  assign win_sad_s = take_s ? total_s : best_q;

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cand_d     = cand_q;
    acc_d      = acc_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    mvx_d      = mvx_q;
    mvy_d      = mvy_q;
    best_sad_d = best_sad_q;
    mv_valid_d = 1'b0;
    case (state_q)
      ACCUM: begin
        if (accept_s) begin
          if (last_row_s) begin
            acc_d      = '0;
            row_d      = '0;
            best_d     = win_sad_s;
            best_idx_d = win_idx_s;
            if (last_cand_s) begin
              cand_d     = '0;
              state_d    = RESULT;
              mv_valid_d = 1'b1;
              mvx_d      = MV_W'(int'(win_idx_s) % GRID);
              mvy_d      = MV_W'(int'(win_idx_s) / GRID);
              best_sad_d = win_sad_s;
            end else begin
              cand_d = cand_q + CAND_W'(1);
            end
          end else begin
            acc_d = total_s;
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          state_d = ACCUM;
        end
      end
      RESULT: begin
        state_d = ACCUM;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
    in_ready_d = (state_d == ACCUM);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACCUM;
      row_q      <= '0;
      cand_q     <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      mvx_q      <= '0;
      mvy_q      <= '0;
      best_sad_q <= '0;
      mv_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cand_q     <= cand_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      mvx_q      <= mvx_d;
      mvy_q      <= mvy_d;
      best_sad_q <= best_sad_d;
      mv_valid_q <= mv_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.mvx      = mvx_q;
  assign bus.mvy      = mvy_q;
  assign bus.best_sad = best_sad_q;
  assign bus.mv_valid = mv_valid_q;

endmodule

// File: tb/tb_frac_search_grid.sv
// Directed bench for frac_search_grid at default parameters (3x3 grid, 72 beats per block).
module tb_frac_search_grid;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   off_a [9];

  frac_search_grid_if #(.PIX_W(8), .ROW_PIX(8), .ROWS(8), .GRID(3)) bus_if ();

  frac_search_grid #(.PIX_W(8), .ROW_PIX(8), .ROWS(8), .GRID(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] mk_row(input int r, input int add);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      v[i*8 +: 8] = 8'(r * 8 + i + add);
    end
    return v;
  endfunction

  task automatic beat(input logic [63:0] f, input logic [63:0] r);
    bus_if.filter_pix  = f;
    bus_if.ref_pix     = r;
    bus_if.input_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.input_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    bus_if.input_ready = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_offsets(input int zero_a, input int zero_b);
    for (int c = 0; c < 9; c++) begin
      off_a[c] = ((c == zero_a) || (c == zero_b)) ? 0 : 1;
    end
  endtask

  // One full block: 9 candidates x 8 rows, then check the result strobe and outputs.
  task automatic run_block(input string tag, input bit max_mode, input bit gaps,
                           input bit hold_hi, input int ex_mvx, input int ex_mvy,
                           input int ex_sad);
    bit early;
    logic [63:0] f;
    logic [63:0] r;
    early = 1'b0;
    for (int c = 0; c < 9; c++) begin
      for (int rw = 0; rw < 8; rw++) begin
        if (gaps && ($urandom_range(0, 2) == 0)) begin
          idle($urandom_range(1, 3));
          if (bus_if.mv_valid) early = 1'b1;
        end
        if (max_mode) begin
          f = {8{8'hFF}};
          r = '0;
        end else begin
          f = mk_row(rw, off_a[c]);
          r = mk_row(rw, 0);
        end
        beat(f, r);
        if (!((c == 8) && (rw == 7)) && bus_if.mv_valid) early = 1'b1;
      end
    end
    check_eq({tag, " early_valid"}, 32'(early), 32'd0);
    check_eq({tag, " mv_valid"}, 32'(bus_if.mv_valid), 32'd1);
    check_eq({tag, " in_ready_result"}, 32'(bus_if.in_ready), 32'd0);
    check_eq({tag, " mvx"}, 32'(bus_if.mvx), 32'(ex_mvx));
    check_eq({tag, " mvy"}, 32'(bus_if.mvy), 32'(ex_mvy));
    check_eq({tag, " best_sad"}, 32'(bus_if.best_sad), 32'(ex_sad));
    if (hold_hi) begin
      beat({8{8'hFF}}, 64'd0);
    end else begin
      idle(1);
    end
    check_eq({tag, " mv_valid_drop"}, 32'(bus_if.mv_valid), 32'd0);
    check_eq({tag, " in_ready_back"}, 32'(bus_if.in_ready), 32'd1);
    check_eq({tag, " mvx_hold"}, 32'(bus_if.mvx), 32'(ex_mvx));
  endtask

  initial begin
    bit seen_valid;
    int c3_mvx, c3_mvy, c4_mvx, c4_mvy;
    n_checks = 0;
    n_fail   = 0;
    bus_if.filter_pix  = '0;
    bus_if.ref_pix     = '0;
    bus_if.input_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check_eq("rst in_ready", 32'(bus_if.in_ready), 32'd1);
    check_eq("rst mv_valid", 32'(bus_if.mv_valid), 32'd0);
    check_eq("rst mvx", 32'(bus_if.mvx), 32'd0);
    check_eq("rst mvy", 32'(bus_if.mvy), 32'd0);
    check_eq("rst best_sad", 32'(bus_if.best_sad), 32'd0);

`ifdef FRAC_SEARCH_CENTER_BIAS_EN
    c3_mvx = 1; c3_mvy = 1; c4_mvx = 1; c4_mvy = 1;
`else
    c3_mvx = 2; c3_mvy = 0; c4_mvx = 0; c4_mvy = 0;
`endif

    set_offsets(4, 4);
    run_block("centre", 1'b0, 1'b0, 1'b0, 1, 1, 0);
    set_offsets(0, 0);
    run_block("cand0", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    set_offsets(2, 4);
    run_block("tie", 1'b0, 1'b0, 1'b0, c3_mvx, c3_mvy, 0);
    run_block("maxsad", 1'b1, 1'b0, 1'b0, c4_mvx, c4_mvy, 16320);

    // Abort a block after 30 beats with reset.
    seen_valid = 1'b0;
    set_offsets(0, 0);
    for (int b = 0; b < 30; b++) begin
      beat(mk_row(b % 8, off_a[b / 8]), mk_row(b % 8, 0));
      if (bus_if.mv_valid) seen_valid = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("abort no_valid", 32'(seen_valid), 32'd0);
    check_eq("abort mv_valid", 32'(bus_if.mv_valid), 32'd0);
    check_eq("abort mvx", 32'(bus_if.mvx), 32'd0);
    check_eq("abort best_sad", 32'(bus_if.best_sad), 32'd0);
    set_offsets(8, 8);
    run_block("after_abort", 1'b0, 1'b0, 1'b0, 2, 2, 0);

    // Idle gaps plus a beat offered during RESULT, then a gap-free block must still align.
    set_offsets(4, 4);
    run_block("gaps", 1'b0, 1'b1, 1'b1, 1, 1, 0);
    set_offsets(2, 4);
    run_block("post_gaps", 1'b0, 1'b0, 1'b0, c3_mvx, c3_mvy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
